uc_dispatcher: RTL and testbench

//   Consumer end of the unit-clause latency buffer. Each cycle it accepts a prefix of the
//   up-to-NUM_ENGINE clauses the buffer offers. It returns the accepted count so the buffer
//   can advance its head. Accepted clauses are parked in per-engine slots and handed to the
//   BCP engines over valid/ready. It also sequences start and drain, and flags done.

---
 rtl/uc_dispatcher.sv | 106 ++++++++++
 tb/tb_uc_dispatcher.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_dispatcher.sv
// Consumer end of the unit-clause buffer: accepts an offered prefix into free per-engine slots,
// hands slots to BCP engines over valid/ready, and sequences start/drain/done for a solve round.
module uc_dispatcher #(
   parameter  int LIT_IDX_MAX = 1024,
   parameter  int CLA_LENGTH  = 3,
   parameter  int NUM_ENGINE  = 4,
   localparam int VAR_W       = $clog2(LIT_IDX_MAX) + 1,
   localparam int CL_W        = VAR_W * CLA_LENGTH,
   localparam int CNT_W       = $clog2(NUM_ENGINE) + 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       go_in,
   output logic                       start_out,
   input  logic                       start_in,
   input  logic                       empty_in,
   input  logic [NUM_ENGINE*CL_W-1:0] clause_in,
   input  logic [CNT_W-1:0]           clause_released_in,
   output logic [CNT_W-1:0]           clause_received_out,
   output logic [NUM_ENGINE-1:0]      eng_valid_out,
   output logic [NUM_ENGINE*CL_W-1:0] eng_clause_out,
   input  logic [NUM_ENGINE-1:0]      eng_ready_in,
   input  logic [NUM_ENGINE-1:0]      eng_busy_in,
   output logic                       done_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                       state;
   logic [1:0]                       state_nxt;
   logic [NUM_ENGINE-1:0]            slot_valid;
   logic [NUM_ENGINE-1:0][CL_W-1:0]  slot_dat;
   logic [NUM_ENGINE-1:0]            load;
   logic [NUM_ENGINE-1:0][CL_W-1:0]  load_dat;
   logic [CNT_W-1:0]                 free_cnt;
   logic [CNT_W-1:0]                 rel_cnt;
   logic [CNT_W-1:0]                 recv;
   logic [CNT_W-1:0]                 k;
   logic                             accept_en;

   assign start_out           = (state == S_RUN) || (state == S_DRAIN);
   assign done_out            = (state == S_DONE);
   assign accept_en           = start_out && start_in && !reset;
   assign clause_received_out = recv;
   assign eng_valid_out       = slot_valid;
   assign eng_clause_out      = slot_dat;

   // Free count uses registered valids, so a slot handed off this cycle is refilled next cycle at the earliest.
   always_comb begin
      free_cnt = '0;
      for (int e = 0; e < NUM_ENGINE; e++) begin
         if (!slot_valid[e]) free_cnt = free_cnt + CNT_W'(1);
      end
      rel_cnt = (clause_released_in > CNT_W'(NUM_ENGINE)) ? CNT_W'(NUM_ENGINE) : clause_released_in;
      recv    = '0;
      if (accept_en) recv = (rel_cnt < free_cnt) ? rel_cnt : free_cnt;
      load     = '0;
      load_dat = '0;
      k        = '0;
      for (int e = 0; e < NUM_ENGINE; e++) begin
         if (!slot_valid[e] && (k < recv)) begin
            load[e]     = 1'b1;
            load_dat[e] = clause_in[k*CL_W +: CL_W];
            k           = k + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (go_in) state_nxt = S_RUN;
         S_RUN:   if (start_in && empty_in) state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (start_in && !empty_in)
               state_nxt = S_RUN;
            else if (empty_in && !(|slot_valid) && !(|eng_busy_in))
               state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         slot_valid <= '0;
         slot_dat   <= '0;
      end else begin
         state <= state_nxt;
         for (int e = 0; e < NUM_ENGINE; e++) begin
            if (load[e]) begin
               slot_valid[e] <= 1'b1;
               slot_dat[e]   <= load_dat[e];
            end else if (slot_valid[e] && eng_ready_in[e]) begin
               slot_valid[e] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_uc_dispatcher.sv
// Randomized bench for uc_dispatcher: a queue-based buffer/engine model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_uc_dispatcher;

   localparam int NE    = 4;
   localparam int CL_W  = 33;
   localparam int CNT_W = 3;
   localparam int W     = NE * CL_W;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic             clock;
   logic             reset;
   logic             go_in;
   logic             start_out;
   logic             start_in;
   logic             empty_in;
   logic [W-1:0]     clause_in;
   logic [CNT_W-1:0] clause_released_in;
   logic [CNT_W-1:0] clause_received_out;
   logic [NE-1:0]    eng_valid_out;
   logic [W-1:0]     eng_clause_out;
   logic [NE-1:0]    eng_ready_in;
   logic [NE-1:0]    eng_busy_in;
   logic             done_out;

   uc_dispatcher dut (
      .clock(clock), .reset(reset), .go_in(go_in), .start_out(start_out),
      .start_in(start_in), .empty_in(empty_in), .clause_in(clause_in),
      .clause_released_in(clause_released_in), .clause_received_out(clause_received_out),
      .eng_valid_out(eng_valid_out), .eng_clause_out(eng_clause_out),
      .eng_ready_in(eng_ready_in), .eng_busy_in(eng_busy_in), .done_out(done_out)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int checks = 0;
   int errors = 0;

   // stimulus knobs
   logic          rst, go;
   logic [NE-1:0] rdy, busy;
   int            offer_lim;
   logic [CL_W-1:0] bufq[$];

   // model state
   int                        m_phase;
   logic [NE-1:0]             m_valid;
   logic [NE-1:0][CL_W-1:0]   m_dat;
   logic                      m_start_prev;
   logic                      saw_done;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [CL_W-1:0] rnd_clause();
      return CL_W'({$urandom(), $urandom()});
   endfunction

   task automatic step();
      int n, rel_d, rel_eff, exp_recv;
      int fl[$];
      logic exp_start, exp_done;
      @(negedge clock);
      reset        = rst;
      go_in        = go;
      eng_ready_in = rdy;
      eng_busy_in  = busy;
      start_in     = m_start_prev;
      n            = bufq.size();
      empty_in     = (n == 0);
      if (n == 0)                          rel_d = 0;
      else if (offer_lim > NE && n >= NE)  rel_d = offer_lim;
      else                                 rel_d = (n < offer_lim) ? n : offer_lim;
      clause_released_in = CNT_W'(rel_d);
      for (int i = 0; i < NE; i++)
         clause_in[i*CL_W +: CL_W] = (i < rel_d && i < n) ? bufq[i] : rnd_clause();
      #1;
      exp_start = (m_phase == P_RUN) || (m_phase == P_DRAIN);
      exp_done  = (m_phase == P_DONE);
      rel_eff   = (rel_d > NE) ? NE : rel_d;
      for (int e = 0; e < NE; e++) if (!m_valid[e]) fl.push_back(e);
      exp_recv = 0;
      if (!rst && exp_start && m_start_prev)
         exp_recv = (rel_eff < fl.size()) ? rel_eff : fl.size();
      chk("start_out", W'(start_out), W'(exp_start));
      chk("done_out", W'(done_out), W'(exp_done));
      chk("received", W'(clause_received_out), W'(exp_recv));
      chk("eng_valid", W'(eng_valid_out), W'(m_valid));
      chk("eng_clause", eng_clause_out, m_dat);
      if (exp_done) saw_done = 1'b1;
      if (rst) begin
         m_phase = P_IDLE;
         m_valid = '0;
         m_dat   = '0;
         bufq.delete();
      end else begin
         case (m_phase)
            P_IDLE:  if (go) m_phase = P_RUN;
            P_RUN:   if (m_start_prev && n == 0) m_phase = P_DRAIN;
            P_DRAIN: if (m_start_prev && n != 0) m_phase = P_RUN;
                     else if (n == 0 && m_valid == 0 && busy == 0) m_phase = P_DONE;
            default: m_phase = P_IDLE;
         endcase
         for (int e = 0; e < NE; e++) if (m_valid[e] && rdy[e]) m_valid[e] = 1'b0;
         for (int i = 0; i < exp_recv; i++) begin
            m_valid[fl[i]] = 1'b1;
            m_dat[fl[i]]   = bufq[i];
         end
         repeat (exp_recv) void'(bufq.pop_front());
      end
      m_start_prev = exp_start;
   endtask

   logic [CL_W-1:0] ca, cb, cc, ce, cf, ch;
   int   dcnt;
   logic after_done;
   logic aborted;

   initial begin
      reset = 1'b1; go_in = 1'b0; start_in = 1'b0; empty_in = 1'b1;
      clause_in = '0; clause_released_in = '0; eng_ready_in = '0; eng_busy_in = '0;
      rst = 1'b1; go = 1'b0; rdy = '0; busy = '0; offer_lim = 4;
      m_phase = P_IDLE; m_valid = '0; m_dat = '0; m_start_prev = 1'b0; saw_done = 1'b0;

      // reset state, then go
      step();
      rst = 1'b0; go = 1'b1;
      step();
      go = 1'b0;
      step();
      chk("t1_start_after_go", W'(start_out), W'(1));

      // three clauses into empty slots
      ca = rnd_clause(); cb = rnd_clause(); cc = rnd_clause();
      bufq.push_back(ca); bufq.push_back(cb); bufq.push_back(cc);
      step();
      chk("t2_recv3", W'(clause_received_out), W'(3));
      step();
      chk("t2_valid", W'(eng_valid_out), W'(4'b0111));
      chk("t2_slot0", W'(eng_clause_out[0*CL_W +: CL_W]), W'(ca));
      chk("t2_slot1", W'(eng_clause_out[1*CL_W +: CL_W]), W'(cb));
      chk("t2_slot2", W'(eng_clause_out[2*CL_W +: CL_W]), W'(cc));

      // prefix into non-contiguous free slots with a same-cycle handoff
      bufq.push_back(rnd_clause());
      ce = rnd_clause(); cf = rnd_clause();
      bufq.push_back(ce); bufq.push_back(cf); bufq.push_back(rnd_clause());
      step();
      rdy = 4'b1010;
      step();
      ch = rnd_clause();
      bufq.push_back(ch);
      rdy = 4'b0001;
      step();
      chk("t3_valid_before", W'(eng_valid_out), W'(4'b0101));
      chk("t3_recv2", W'(clause_received_out), W'(2));
      rdy = 4'b0000;
      step();
      chk("t3_valid_after", W'(eng_valid_out), W'(4'b1110));
      chk("t3_slot1", W'(eng_clause_out[1*CL_W +: CL_W]), W'(ce));
      chk("t3_slot3", W'(eng_clause_out[3*CL_W +: CL_W]), W'(cf));

      // full slots: nothing accepted, then a released slot is reused one cycle later
      for (int i = 0; i < 3; i++) bufq.push_back(rnd_clause());
      rdy = 4'b0100;
      step();
      chk("t4_full_recv0", W'(clause_received_out), W'(0));
      rdy = 4'b0000;
      step();
      chk("t4_recv1", W'(clause_received_out), W'(1));
      step();
      chk("t4_valid_full", W'(eng_valid_out), W'(4'b1111));
      chk("t4_slot2", W'(eng_clause_out[2*CL_W +: CL_W]), W'(ch));

      // drain to done
      rdy = 4'b1111; busy = '0; dcnt = 0; after_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (after_done) begin
            chk("t5_start_low_after_done", W'(start_out), W'(0));
            after_done = 1'b0;
         end
         if (done_out) begin
            dcnt++;
            after_done = 1'b1;
         end
      end
      chk("t5_done_pulses", W'(dcnt), W'(1));

      // reset mid-round with occupied slots
      rdy = '0; go = 1'b1;
      step();
      go = 1'b0;
      for (int i = 0; i < 3; i++) bufq.push_back(rnd_clause());
      step();
      step();
      step();
      chk("t6_valid_pre", W'(eng_valid_out), W'(4'b0111));
      rst = 1'b1; rdy = 4'b1111;
      step();
      rst = 1'b0; rdy = '0;
      step();
      chk("t6_valid_zero", W'(eng_valid_out), W'(0));
      chk("t6_start_zero", W'(start_out), W'(0));
      chk("t6_clause_zero", eng_clause_out, W'(0));

      // randomized rounds
      for (int r = 0; r < 8; r++) begin
         int feed_len;
         feed_len = $urandom_range(10, 60);
         saw_done = 1'b0;
         aborted  = 1'b0;
         for (int i = 0; i < 4; i++) bufq.push_back(rnd_clause());
         go = 1'b1;
         for (int c = 0; c < 800 && !saw_done; c++) begin
            step();
            go        = ($urandom_range(0, 15) == 0);
            rdy       = NE'($urandom());
            offer_lim = $urandom_range(0, 7);
            if (c < feed_len) begin
               repeat ($urandom_range(0, 2)) bufq.push_back(rnd_clause());
               busy = NE'($urandom());
            end else begin
               if (c < feed_len + 40 && $urandom_range(0, 19) == 0) bufq.push_back(rnd_clause());
               busy = ($urandom_range(0, 3) == 0) ? NE'($urandom()) : '0;
            end
            if (r == 3 && c == 15) begin
               rst = 1'b1;
               step();
               rst = 1'b0;
               aborted = 1'b1;
               break;
            end
         end
         go = 1'b0;
         if (!aborted) chk("round_done", W'(saw_done), W'(1));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
